// File: rtl/otter_pkg.sv
// Shared OTTER register-file constants and the write-request record used by
// the writeback arbiter and its result FIFO.
package otter_pkg;
   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] wa;
      logic [XLEN-1:0]       wd;
   } wb_req_t;
endpackage

// File: rtl/wb_fifo.sv
// Small circular FIFO of register writes. Exposes per-entry valid bits and
// addresses so the parent can build a pending-register mask.
module wb_fifo
   import otter_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  push,
   input  wb_req_t                               tail_req,
   input  logic                                  pop,
   output logic                                  full,
   output logic                                  empty,
   output wb_req_t                               head,
   output logic [DEPTH-1:0]                      ent_vld,
   output logic [DEPTH-1:0][REG_ADDR_W-1:0]      ent_wa
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   wb_req_t          mem [DEPTH];
   logic [AW-1:0]    rd_ptr, wr_ptr;
   logic [CW-1:0]    count;
   logic [DEPTH-1:0] vld;
   logic             push_ok, pop_ok;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign head    = mem[rd_ptr];
   assign ent_vld = vld;

   always_comb begin
      ent_wa = '0;
      for (int i = 0; i < DEPTH; i++) ent_wa[i] = mem[i].wa;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         vld    <= '0;
      end else begin
         // Clear before set so a same-slot pop/push (only possible when full,
         // which push_ok excludes) can never lose the new entry.
         if (pop_ok) begin
            vld[rd_ptr] <= 1'b0;
            rd_ptr      <= rd_ptr + AW'(1);
         end
         if (push_ok) begin
            mem[wr_ptr] <= tail_req;
            vld[wr_ptr] <= 1'b1;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         case ({push_ok, pop_ok})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback always wins, buffered
// multi-cycle results drain into idle slots in acceptance order.
module rf_wb_arbiter
   import otter_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  WB_EN,
   input  logic [REG_ADDR_W-1:0] WB_WA,
   input  logic [XLEN-1:0]       WB_WD,
   input  logic                  MC_VALID,
   input  logic [REG_ADDR_W-1:0] MC_WA,
   input  logic [XLEN-1:0]       MC_WD,
   output logic                  MC_READY,
   output logic                  RF_EN,
   output logic [REG_ADDR_W-1:0] RF_WA,
   output logic [XLEN-1:0]       RF_WD,
   output logic [XLEN-1:0]       PEND_MASK
);
   logic                             full, empty, push, pop;
   wb_req_t                          head, tail_req;
   logic [DEPTH-1:0]                 ent_vld;
   logic [DEPTH-1:0][REG_ADDR_W-1:0] ent_wa;

   // READY comes from the registered fill level only, never from this cycle's pop.
   assign MC_READY = !RST && !full;
   assign push     = MC_VALID && MC_READY && (MC_WA != '0);
   assign pop      = !RST && !WB_EN && !empty;
   assign tail_req = '{wa: MC_WA, wd: MC_WD};

   wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk      (CLK),
      .rst      (RST),
      .push     (push),
      .tail_req (tail_req),
      .pop      (pop),
      .full     (full),
      .empty    (empty),
      .head     (head),
      .ent_vld  (ent_vld),
      .ent_wa   (ent_wa)
   );

   always_comb begin
      RF_EN = 1'b0;
      RF_WA = '0;
      RF_WD = '0;
      if (!RST) begin
         if (WB_EN) begin
            RF_EN = 1'b1;
            RF_WA = WB_WA;
            RF_WD = WB_WD;
         end else if (!empty) begin
            RF_EN = 1'b1;
            RF_WA = head.wa;
            RF_WD = head.wd;
         end
      end
   end

   always_comb begin
      PEND_MASK = '0;
      if (!RST)
         for (int i = 0; i < DEPTH; i++)
            if (ent_vld[i]) PEND_MASK[ent_wa[i]] = 1'b1;
      PEND_MASK[0] = 1'b0;
   end
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed scenarios plus a randomized
// run scored against a queue-based model of the write port.
module tb_rf_wb_arbiter;
   localparam int DEPTH = 4;

   logic        CLK = 0, RST = 1;
   logic        WB_EN = 0, MC_VALID = 0;
   logic [4:0]  WB_WA = 0, MC_WA = 0;
   logic [31:0] WB_WD = 0, MC_WD = 0;
   logic        MC_READY, RF_EN;
   logic [4:0]  RF_WA;
   logic [31:0] RF_WD, PEND_MASK;

   int n_tests = 0, n_fail = 0;

   rf_wb_arbiter #(.DEPTH(DEPTH)) dut (
      .CLK(CLK), .RST(RST), .WB_EN(WB_EN), .WB_WA(WB_WA), .WB_WD(WB_WD),
      .MC_VALID(MC_VALID), .MC_WA(MC_WA), .MC_WD(MC_WD), .MC_READY(MC_READY),
      .RF_EN(RF_EN), .RF_WA(RF_WA), .RF_WD(RF_WD), .PEND_MASK(PEND_MASK)
   );

   always #5 CLK = ~CLK;

   // Reference model: the buffered writes as a plain queue.
   typedef struct { logic [4:0] wa; logic [31:0] wd; } ent_t;
   ent_t q[$];
   logic last_acc = 0;

   function automatic logic m_ready();
      return !RST && (q.size() < DEPTH);
   endfunction
   function automatic logic [31:0] m_pend();
      logic [31:0] m = 0;
      if (!RST) foreach (q[i]) m = m | (32'd1 << q[i].wa);
      m[0] = 1'b0;
      return m;
   endfunction
   function automatic logic m_en();
      return !RST && (WB_EN || q.size() > 0);
   endfunction
   function automatic logic [4:0] m_wa();
      if (RST) return 0;
      if (WB_EN) return WB_WA;
      return (q.size() > 0) ? q[0].wa : 5'd0;
   endfunction
   function automatic logic [31:0] m_wd();
      if (RST) return 0;
      if (WB_EN) return WB_WD;
      return (q.size() > 0) ? q[0].wd : 32'd0;
   endfunction

   always @(posedge CLK) begin
      last_acc = MC_VALID && m_ready();
      if (RST) q.delete();
      else begin
         if (!WB_EN && q.size() > 0) void'(q.pop_front());
         if (last_acc && MC_WA != 0) q.push_back('{MC_WA, MC_WD});
      end
   end

   // Stimulus legality: the hazard unit never writes back a pending register.
   always @(negedge CLK)
      if (!RST && WB_EN && m_pend()[WB_WA]) begin
         n_fail++;
         $display("FAIL hazard_rule: WB_WA=%0d written while pending mask=%h", WB_WA, m_pend());
      end

   task automatic next();
      @(posedge CLK); #1;
   endtask

   task automatic test_reset();
      RST = 1; MC_VALID = 1; MC_WA = 5; MC_WD = 32'h55; WB_EN = 0;
      repeat (2) begin
         @(negedge CLK);
         n_tests++;
         if ({MC_READY, RF_EN, RF_WA, RF_WD, PEND_MASK} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: ready=%b en=%b wa=%0d wd=%h pend=%h, required all 0",
                     MC_READY, RF_EN, RF_WA, RF_WD, PEND_MASK);
         end
         next();
      end
      RST = 0; MC_VALID = 0;
      @(negedge CLK);
      n_tests++;
      if (MC_READY !== 1'b1 || RF_EN !== 1'b0 || PEND_MASK !== 0) begin
         n_fail++;
         $display("FAIL reset_release: ready=%b en=%b pend=%h, required 1 0 0", MC_READY, RF_EN, PEND_MASK);
      end
      next();
   endtask

   task automatic test_idle_drain();
      WB_EN = 0; MC_VALID = 1; MC_WA = 7; MC_WD = 32'hDEADBEEF;
      @(negedge CLK);
      n_tests++;
      if (MC_READY !== 1'b1 || RF_EN !== 1'b0) begin
         n_fail++;
         $display("FAIL drain_accept: ready=%b en=%b, required 1 0", MC_READY, RF_EN);
      end
      next(); MC_VALID = 0;
      @(negedge CLK);
      n_tests++;
      if (PEND_MASK !== 32'h80 || RF_EN !== 1'b1 || RF_WA !== 5'd7 || RF_WD !== 32'hDEADBEEF) begin
         n_fail++;
         $display("FAIL drain_write: pend=%h en=%b wa=%0d wd=%h, required 80 1 7 deadbeef",
                  PEND_MASK, RF_EN, RF_WA, RF_WD);
      end
      next();
      @(negedge CLK);
      n_tests++;
      if (PEND_MASK !== 0 || RF_EN !== 1'b0) begin
         n_fail++;
         $display("FAIL drain_clear: pend=%h en=%b, required 0 0", PEND_MASK, RF_EN);
      end
      next();
   endtask

   task automatic test_priority();
      WB_EN = 1; WB_WA = 3; WB_WD = 32'h11;
      for (int c = 0; c < 6; c++) begin
         MC_VALID = (c < 4); MC_WA = 5'(8 + c); MC_WD = 32'(100 + c);
         @(negedge CLK);
         n_tests++;
         if (RF_EN !== 1'b1 || RF_WA !== 5'd3 || RF_WD !== 32'h11 || MC_READY !== (c < 4)) begin
            n_fail++;
            $display("FAIL prio_wb c=%0d: en=%b wa=%0d wd=%h ready=%b, required 1 3 11 %b",
                     c, RF_EN, RF_WA, RF_WD, MC_READY, c < 4);
         end
         next();
      end
      WB_EN = 0; MC_VALID = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge CLK);
         n_tests++;
         if (RF_EN !== 1'b1 || RF_WA !== 5'(8 + c) || RF_WD !== 32'(100 + c) || MC_READY !== (c != 0)) begin
            n_fail++;
            $display("FAIL prio_drain c=%0d: en=%b wa=%0d wd=%0d ready=%b, required 1 %0d %0d %b",
                     c, RF_EN, RF_WA, RF_WD, MC_READY, 8 + c, 100 + c, c != 0);
         end
         next();
      end
      @(negedge CLK);
      n_tests++;
      if (RF_EN !== 1'b0 || PEND_MASK !== 0) begin
         n_fail++;
         $display("FAIL prio_empty: en=%b pend=%h, required 0 0", RF_EN, PEND_MASK);
      end
      next();
   endtask

   task automatic test_same_reg();
      logic [31:0] exp_wd [2] = '{32'd1, 32'd2};
      WB_EN = 0; MC_VALID = 1; MC_WA = 4; MC_WD = 1;
      next();
      MC_WD = 2;
      for (int c = 0; c < 2; c++) begin
         @(negedge CLK);
         n_tests++;
         if (RF_EN !== 1'b1 || RF_WA !== 5'd4 || RF_WD !== exp_wd[c] || PEND_MASK[4] !== 1'b1) begin
            n_fail++;
            $display("FAIL same_reg c=%0d: en=%b wa=%0d wd=%0d pend4=%b, required 1 4 %0d 1",
                     c, RF_EN, RF_WA, RF_WD, PEND_MASK[4], exp_wd[c]);
         end
         next(); MC_VALID = 0;
      end
      @(negedge CLK);
      n_tests++;
      if (RF_EN !== 1'b0 || PEND_MASK !== 0) begin
         n_fail++;
         $display("FAIL same_reg_clear: en=%b pend=%h, required 0 0", RF_EN, PEND_MASK);
      end
      next();
   endtask

   task automatic test_x0_drop();
      WB_EN = 0; MC_VALID = 1; MC_WA = 0; MC_WD = 32'hFFFFFFFF;
      @(negedge CLK);
      n_tests++;
      if (MC_READY !== 1'b1) begin
         n_fail++;
         $display("FAIL x0_ready: ready=%b, required 1", MC_READY);
      end
      next(); MC_VALID = 0;
      for (int c = 0; c < 2; c++) begin
         @(negedge CLK);
         n_tests++;
         if (RF_EN !== 1'b0 || PEND_MASK !== 0 || MC_READY !== 1'b1) begin
            n_fail++;
            $display("FAIL x0_drop c=%0d: en=%b pend=%h ready=%b, required 0 0 1", c, RF_EN, PEND_MASK, MC_READY);
         end
         next();
      end
   endtask

   task automatic test_reset_mid();
      WB_EN = 1; WB_WA = 1; WB_WD = 32'h77;
      for (int c = 0; c < 3; c++) begin
         MC_VALID = 1; MC_WA = 5'(12 + c); MC_WD = 32'(c);
         next();
      end
      MC_VALID = 0;
      @(negedge CLK);
      n_tests++;
      if (PEND_MASK !== 32'h7000) begin
         n_fail++;
         $display("FAIL mid_buffered: pend=%h, required 7000", PEND_MASK);
      end
      next();
      RST = 1; WB_EN = 0;
      @(negedge CLK);
      n_tests++;
      if (RF_EN !== 1'b0 || PEND_MASK !== 0 || MC_READY !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_rst: en=%b pend=%h ready=%b, required 0 0 0", RF_EN, PEND_MASK, MC_READY);
      end
      next(); RST = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge CLK);
         n_tests++;
         if (RF_EN !== 1'b0 || PEND_MASK !== 0 || MC_READY !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_after c=%0d: en=%b pend=%h ready=%b, required 0 0 1", c, RF_EN, PEND_MASK, MC_READY);
         end
         next();
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 600; c++) begin
         // A held result changes only once accepted.
         if (!MC_VALID || last_acc) begin
            MC_VALID = ($urandom_range(0, 2) != 0);
            MC_WA    = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            MC_WD    = $urandom;
         end
         WB_EN = ($urandom_range(0, 2) == 0);
         WB_WD = $urandom;
         WB_WA = 5'($urandom_range(0, 31));
         for (int k = 0; k < 32 && m_pend()[WB_WA]; k++) WB_WA = WB_WA + 5'd1;
         if (m_pend()[WB_WA]) WB_EN = 0;
         @(negedge CLK);
         n_tests++;
         if (RF_EN !== m_en() || RF_WA !== m_wa() || RF_WD !== m_wd() ||
             PEND_MASK !== m_pend() || MC_READY !== m_ready()) begin
            n_fail++;
            $display("FAIL random c=%0d: en=%b wa=%0d wd=%h pend=%h ready=%b, required %b %0d %h %h %b",
                     c, RF_EN, RF_WA, RF_WD, PEND_MASK, MC_READY,
                     m_en(), m_wa(), m_wd(), m_pend(), m_ready());
         end
         next();
      end
      WB_EN = 0; MC_VALID = 0;
   endtask

   initial begin
      test_reset();
      test_idle_drain();
      test_priority();
      test_same_reg();
      test_x0_drop();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
